// File: rtl/spi_reg_slave.sv
// SPI mode-3 register responder: 2^ADDR_W x 8 register file, oversampled link.
// Register 0 holds a fixed device ID; a local parallel port loads the file.
`timescale 1ns/1ps
module spi_reg_slave #(
  parameter int          ADDR_W      = 6,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID       = 8'hE5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO,
  output logic              miso_oe,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE, S_CMD, S_RD, S_WR
  } state_t;

  state_t r_state, w_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  logic [7:0]        r_regs [DEPTH];
  logic [2:0]        r_bitcnt;
  logic [7:0]        r_shift;
  logic [7:0]        r_tx;
  logic [ADDR_W-1:0] r_addr;
  logic              r_mb;

  logic              w_sclk, w_cs, w_mosi;
  logic              w_rise, w_fall, w_cs_fall;
  logic              w_last, w_spi_we;
  logic [7:0]        w_byte;
  logic [ADDR_W-1:0] w_naddr, w_cmd_addr;

  assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise    = w_sclk & ~r_sclk_d & ~w_cs;
  assign w_fall    = ~w_sclk & r_sclk_d & ~w_cs;
  assign w_cs_fall = ~w_cs & r_cs_d;

  assign w_byte     = {r_shift[6:0], w_mosi};
  assign w_last     = w_rise && (r_bitcnt == 3'd7);
  assign w_cmd_addr = w_byte[ADDR_W-1:0];
  assign w_naddr    = r_mb ? r_addr + 1'b1 : r_addr;
  assign w_spi_we   = (r_state == S_WR) && w_last
                      && (r_addr != '0);

  assign busy = (r_state != S_IDLE);

  // CS chain resets "asserted" so a CS held low across reset is not a new frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_sync <= '1;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b1;
      r_cs_d      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_cs_fall) w_next = S_CMD;
      S_CMD: begin
        if (w_cs)        w_next = S_IDLE;
        else if (w_last) w_next = w_byte[7] ? S_RD : S_WR;
      end
      S_RD, S_WR: if (w_cs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_tx      <= '0;
      r_addr    <= '0;
      r_mb      <= 1'b0;
      MISO      <= 1'b0;
      miso_oe   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (w_next == S_IDLE || r_state == S_IDLE) begin
        r_bitcnt <= '0;
        MISO     <= 1'b0;
        miso_oe  <= 1'b0;
      end else begin
        if (w_rise) begin
          r_shift  <= w_byte;
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        unique case (r_state)
          S_CMD: if (w_last) begin
            r_mb   <= w_byte[6];
            r_addr <= w_cmd_addr;
            if (w_byte[7]) begin
              r_tx    <= r_regs[w_cmd_addr];
              miso_oe <= 1'b1;
            end
          end
          S_RD: begin
            if (w_fall) begin
              MISO <= r_tx[7];
              r_tx <= {r_tx[6:0], 1'b0};
            end
            if (w_last) begin
              r_addr <= w_naddr;
              r_tx   <= r_regs[w_naddr];
            end
          end
          S_WR: if (w_last) begin
            wr_strobe <= 1'b1;
            wr_addr   <= r_addr;
            wr_data   <= w_byte;
            r_addr    <= w_naddr;
          end
          default: ;
        endcase
      end
    end
  end

  // SPI write is assigned last so it wins a same-cycle load collision
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regs[0] <= DEVID;
      for (int i = 1; i < DEPTH; i++)
        r_regs[i[ADDR_W-1:0]] <= '0;
    end else begin
      if (ld_en && ld_addr != '0)
        r_regs[ld_addr] <= ld_data;
      if (w_spi_we)
        r_regs[r_addr] <= w_byte;
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: vector table of single-byte frames
// plus hand sequences for wrap, abort, collision and mid-frame reset.
`timescale 1ns/1ps
module tb_spi_reg_slave;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       SCLK = 1'b1;
  logic       CS = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO, miso_oe;
  logic       ld_en = 1'b0;
  logic [5:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic       wr_strobe;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  spi_reg_slave dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
    .MISO(MISO), .miso_oe(miso_oe), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_strobe = 0;
  logic [5:0] last_wa = '0;
  logic [7:0] last_wd = '0;

  always @(posedge clk) begin
    if (wr_strobe === 1'b1) begin
      n_strobe++;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
  end

  initial begin
    #(500_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic ld(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // one SCLK period: fall, 4 clk, rise, 4 clk; MISO sampled just before rise
  task automatic sbit(input logic b, output logic r, output logic o);
    @(negedge clk);
    SCLK = 1'b0; MOSI = b;
    repeat (3) @(negedge clk);
    r = MISO; o = miso_oe;
    @(negedge clk);
    SCLK = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic xbyte(input logic [7:0] tx, output logic [7:0] rx,
                       output logic oe_all, output logic oe_any);
    logic r, o;
    oe_all = 1'b1; oe_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      sbit(tx[i], r, o);
      rx[i] = r;
      oe_all &= o;
      oe_any |= o;
    end
  endtask

  logic [7:0] tx_buf [4];
  logic [7:0] rx_buf [4];
  logic f_cmd_oe, f_oe_all, f_oe_any, f_busy_mid, f_busy_end;

  task automatic cs_low();
    @(negedge clk);
    CS = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic cs_high_settle();
    CS = 1'b1; MOSI = 1'b0;
    repeat (3) @(posedge clk);
    #1 f_busy_end = busy;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] cmd, input int n);
    logic [7:0] d;
    logic a, y;
    cs_low();
    xbyte(cmd, d, a, y);
    f_cmd_oe = y;
    f_oe_all = 1'b1; f_oe_any = 1'b0;
    for (int i = 0; i < n; i++) begin
      xbyte(tx_buf[i], d, a, y);
      rx_buf[i] = d;
      f_oe_all &= a;
      f_oe_any |= y;
    end
    f_busy_mid = busy;
    cs_high_settle();
  endtask

  task automatic rd1(input string nm, input logic [5:0] a,
                     input logic [7:0] exp);
    tx_buf[0] = 8'h00;
    frame({2'b10, a}, 1);
    chk(nm, rx_buf[0], exp);
  endtask

  typedef struct {
    logic       rw;
    logic [5:0] addr;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 8;
  vec_t tbl [NV];

  initial begin
    logic [7:0] d;
    logic r, o, a, y;
    int n0;

    tbl[0] = '{1'b0, 6'h20, 8'h27, 8'h00};
    tbl[1] = '{1'b1, 6'h20, 8'h00, 8'h27};
    tbl[2] = '{1'b1, 6'h00, 8'h00, 8'hE5};
    tbl[3] = '{1'b0, 6'h05, 8'h81, 8'h00};
    tbl[4] = '{1'b1, 6'h05, 8'h00, 8'h81};
    tbl[5] = '{1'b0, 6'h00, 8'hFF, 8'h00};
    tbl[6] = '{1'b1, 6'h00, 8'h00, 8'hE5};
    tbl[7] = '{1'b1, 6'h06, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) tx_buf[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst MISO", MISO, 0);
    chk("rst miso_oe", miso_oe, 0);
    chk("rst wr_strobe", wr_strobe, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      n0 = n_strobe;
      tx_buf[0] = tbl[k].wd;
      frame({tbl[k].rw, 1'b0, tbl[k].addr}, 1);
      if (tbl[k].rw) begin
        chk($sformatf("v%0d rx", k), rx_buf[0], tbl[k].exp);
        chk($sformatf("v%0d oe data", k), f_oe_all, 1);
        chk($sformatf("v%0d oe cmd", k), f_cmd_oe, 0);
      end else begin
        chk($sformatf("v%0d strobes", k), n_strobe - n0, 1);
        chk($sformatf("v%0d wr_addr", k), last_wa, tbl[k].addr);
        chk($sformatf("v%0d wr_data", k), last_wd, tbl[k].wd);
        chk($sformatf("v%0d oe", k), f_oe_any, 0);
      end
      chk($sformatf("v%0d busy mid", k), f_busy_mid, 1);
      chk($sformatf("v%0d busy end", k), f_busy_end, 0);
      chk($sformatf("v%0d oe end", k), miso_oe, 0);
    end

    // mb=0: the same register is re-read
    tx_buf[0] = 8'h00; tx_buf[1] = 8'h00;
    frame(8'hA0, 2);
    chk("mb0 rd b0", rx_buf[0], 8'h27);
    chk("mb0 rd b1", rx_buf[1], 8'h27);

    // mb=1 write wrapping 0x3F -> 0x00: reg 0 protected, strobe still fires
    n0 = n_strobe;
    tx_buf[0] = 8'h12; tx_buf[1] = 8'h34;
    frame(8'h7F, 2);
    chk("wrap wr strobes", n_strobe - n0, 2);
    chk("wrap wr last addr", last_wa, 6'h00);
    chk("wrap wr last data", last_wd, 8'h34);
    rd1("wrap wr 3F", 6'h3F, 8'h12);
    rd1("wrap wr 00", 6'h00, 8'hE5);

    // multi-byte read across the wrap
    ld(6'h3E, 8'hA5);
    ld(6'h3F, 8'h5A);
    ld(6'h01, 8'h3C);
    for (int i = 0; i < 4; i++) tx_buf[i] = 8'h00;
    frame(8'hFE, 3);
    chk("mb rd b0", rx_buf[0], 8'hA5);
    chk("mb rd b1", rx_buf[1], 8'h5A);
    chk("mb rd b2", rx_buf[2], 8'hE5);
    chk("mb rd oe", f_oe_all, 1);

    // ld_en to address 0 is ignored
    ld(6'h00, 8'h42);
    rd1("ld addr0", 6'h00, 8'hE5);

    // partial byte at CS deassert is discarded
    ld(6'h24, 8'h4B);
    n0 = n_strobe;
    cs_low();
    xbyte(8'h24, d, a, y);
    for (int i = 7; i > 2; i--) begin
      d = 8'hC3;
      sbit(d[i], r, o);
    end
    cs_high_settle();
    chk("abort strobes", n_strobe - n0, 0);
    chk("abort busy end", f_busy_end, 0);
    rd1("abort reg24", 6'h24, 8'h4B);

    // SPI write and ld_en to the same address in the same cycle
    cs_low();
    xbyte(8'h10, d, a, y);
    for (int i = 7; i > 0; i--) begin
      d = 8'h11;
      sbit(d[i], r, o);
    end
    @(negedge clk);
    SCLK = 1'b0; MOSI = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    SCLK = 1'b1;
    repeat (2) @(negedge clk);
    ld_en = 1'b1; ld_addr = 6'h10; ld_data = 8'h99;
    @(negedge clk);
    ld_en = 1'b0;
    chk("collision align", wr_strobe, 1);
    repeat (3) @(negedge clk);
    cs_high_settle();
    rd1("collision reg10", 6'h10, 8'h11);

    // reset during the 3rd data bit of a read of 0x3E (A5 = 1010_0101)
    cs_low();
    xbyte(8'hBE, d, a, y);
    sbit(1'b0, r, o);
    sbit(1'b0, r, o);
    @(negedge clk);
    SCLK = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset MISO", MISO, 1);
    chk("pre-reset oe", miso_oe, 1);
    reset = 1'b0;
    #1;
    chk("mid rst MISO", MISO, 0);
    chk("mid rst oe", miso_oe, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst wr_addr", wr_addr, 0);
    chk("mid rst wr_data", wr_data, 0);
    @(negedge clk);
    SCLK = 1'b1; CS = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    rd1("post rst 00", 6'h00, 8'hE5);
    rd1("post rst 3E", 6'h3E, 8'h00);
    rd1("post rst 10", 6'h10, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
- SPI responder (mode 3: CPOL=1, CPHA=1) at the far end of the link driven by SPIMaster; stands in for the accelerometer register interface.
- Holds a 64 x 8 register file. The SPI side reads and writes it. Local sensor logic loads it through a parallel port.
- SCLK, CS and MOSI are oversampled in the clk domain; no logic is clocked by SCLK.

Parameters:
- ADDR_W, 6, register address width; the file is 2^ADDR_W bytes.
- SYNC_STAGES, 2, flip-flop stages on each of SCLK, CS and MOSI (minimum 2).
- DEVID, 8'hE5, reset and permanent value of register 0x00, which is read-only.

Ports:
- clk  in  1  system clock; must run at 8 x SCLK or faster.
- reset  in  1  asynchronous, active-low reset.
- SCLK  in  1  SPI clock from the master; idles high.
- CS  in  1  chip select, active-low.
- MOSI  in  1  serial data from the master, MSB first.
- MISO  out  1  serial data to the master, MSB first.
- miso_oe  out  1  MISO output enable; 1 only while a read data phase is active.
- ld_en  in  1  local register load strobe.
- ld_addr  in  ADDR_W  local load address.
- ld_data  in  8  local load data.
- wr_strobe  out  1  one-cycle pulse on each completed SPI write.
- wr_addr  out  ADDR_W  address of the last SPI write.
- wr_data  out  8  data of the last SPI write.
- busy  out  1  synchronized CS is active.

Behaviour:
- Reset (reset=0, asynchronous):
  - MISO, miso_oe, wr_strobe, wr_addr, wr_data and busy all go to 0.
  - All registers clear to 0, except register 0 = DEVID.
  - FSM goes to IDLE.
- Synchronizers: SCLK, CS and MOSI each pass through SYNC_STAGES flip-flops. Rising and falling SCLK edges are detected on the synchronized copy, one clk after it changes.
- Frame format: command byte {rw, mb, addr[5:0]}, then data bytes.
  - rw=1 is a read; rw=0 is a write.
  - mb=1 auto-increments the address after each data byte.
- MOSI is sampled on SCLK rising edges. MISO is updated on SCLK falling edges.
- MISO settles within SYNC_STAGES+2 clk cycles of the SCLK fall.
- FSM states:
  - IDLE: on CS falling, go to CMD with bit count = 0 and busy=1.
  - CMD: shift in 8 bits. On the 8th rising edge, latch rw, mb and addr. Go to RD if rw=1, otherwise WR.
  - RD:
    - On entry and at each byte boundary, copy reg[addr] into the output shift register.
    - miso_oe=1. The MSB appears on the first falling edge after the command byte.
    - After 8 bits, advance addr if mb=1, then reload.
  - WR:
    - After 8 rising edges, write reg[addr] <= byte, unless addr=0.
    - Pulse wr_strobe for 1 clk with wr_addr/wr_data; this pulse also fires when addr=0.
    - Advance addr if mb=1.
  - Any state: CS rising returns the FSM to IDLE with miso_oe=0, MISO=0 and busy=0.
- Address wrap: 0x3F increments to 0x00. With mb=0 the address stays fixed, so repeated bytes re-read or re-write the same register.
- Partial byte at CS deassert: discarded. No write and no wr_strobe.
- Read snapshot: the value is taken at the byte boundary. A ld_en after the snapshot does not affect the byte in flight.
- Load collision: ld_en and an SPI write to the same address in the same clk cycle means the SPI write wins. ld_en to address 0 is ignored.
- Reset asserted mid-frame: takes effect immediately. After reset releases, the responder waits for a fresh CS falling edge before accepting a frame.

Test Plan:
- Register write: frame {0,0,0x20} then 8'h27 → reg[0x20]=0x27; exactly one wr_strobe with wr_addr=0x20, wr_data=0x27; busy falls within 3 clk of CS rising.
- Device-ID read: frame {1,0,0x00} plus one dummy byte → MISO returns 0xE5 MSB first; miso_oe=1 only during the data byte.
- Multi-byte read with wrap: after ld_en preloads 0x3E=0xA5, 0x3F=0x5A, 0x01=0x3C, frame {1,1,0x3E} plus 3 bytes → MISO returns A5, 5A, E5.
- Abort and read-only protection:
  - CS raised after 5 data bits of a write to 0x24 → reg[0x24] unchanged, no wr_strobe.
  - Write 0xFF to 0x00 → still reads 0xE5.
- Collision: SPI write 0x11 to 0x10 in the same cycle as ld_en writing 0x99 to 0x10 → reg[0x10]=0x11.
- Reset mid-read: reset=0 during the 3rd data bit → MISO=0 and miso_oe=0 immediately, registers cleared. After release, the next frame {1,0,0x00} returns 0xE5.
